// File: rtl/difftest_int_wb_sink_if.sv
// Writeback event stream from the difftest producer into the integer writeback sink.
interface difftest_int_wb_sink_if;
  logic        io_valid;
  logic [7:0]  io_address;
  logic [63:0] io_data;
  logic [7:0]  io_coreid;
  logic        io_ready;

  modport master (output io_valid, io_address, io_data, io_coreid, input io_ready);
  modport slave  (input io_valid, io_address, io_data, io_coreid, output io_ready);
endinterface

// File: rtl/difftest_int_wb_sink.sv
// Buffers difftest integer writebacks into a 32x64 shadow regfile with read port and dump sequencer.
// Optional event counters are built when DIFFTEST_WB_STATS_EN is defined.
module difftest_int_wb_sink #(
  parameter int unsigned CORE_ID = 0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  difftest_int_wb_sink_if.slave wb,
  input  logic [4:0]            rd_addr,
  output logic [63:0]           rd_data,
  output logic                  rd_pending,
  input  logic                  dump_req,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [4:0]            dump_addr,
  output logic [63:0]           dump_data,
  output logic                  dump_busy,
  output logic [31:0]           wb_count,
  output logic [15:0]           drop_count
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned NREG = 32;

  typedef enum logic {IDLE, DUMP} state_e;

  state_e        state_q;
  logic [63:0]   regfile_q   [NREG];
  logic [4:0]    fifo_addr_q [DEPTH];
  logic [63:0]   fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_vld_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   rd_data_q;
  logic [4:0]    dump_addr_q;

  logic        offer, discard, push_req, full, empty, push, pop, rf_we;
  logic [4:0]  pop_addr;
  logic [63:0] pop_data;

  assign offer    = enable && wb.io_valid && (wb.io_coreid == 8'(CORE_ID));
  assign discard  = (wb.io_address >= 8'd32) || (wb.io_address == 8'd0);
  assign push_req = offer && !discard;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = push_req && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign pop_addr = fifo_addr_q[rd_ptr_q];
  assign pop_data = fifo_data_q[rd_ptr_q];
  assign rf_we    = pop && (pop_addr != 5'd0);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  assign wb.io_ready = !full;
  assign rd_data     = rd_data_q;
  assign dump_valid  = (state_q == DUMP);
  assign dump_busy   = (state_q == DUMP);
  assign dump_addr   = dump_addr_q;
  assign dump_data   = regfile_q[dump_addr_q];

  // Event FIFO; full is evaluated before the same-cycle pop, so a push into a full FIFO is lost.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_vld_q <= '0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= wb.io_address[4:0];
        fifo_data_q[wr_ptr_q] <= wb.io_data;
        fifo_vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        fifo_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld_q[i] && (fifo_addr_q[i] == rd_addr)) rd_pending = 1'b1;
    end
    if (rd_addr == 5'd0) rd_pending = 1'b0;
  end

  // Shadow regfile with write-first registered read port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regfile_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (rf_we) regfile_q[pop_addr] <= pop_data;
      if (rf_we && (pop_addr == rd_addr)) rd_data_q <= pop_data;
      else                                rd_data_q <= regfile_q[rd_addr];
    end
  end

  // Dump sequencer; draining is frozen while in DUMP so beats form a consistent snapshot.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dump_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_req) begin
            state_q     <= DUMP;
            dump_addr_q <= '0;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_addr_q == 5'd31) begin
              state_q     <= IDLE;
              dump_addr_q <= '0;
            end else begin
              dump_addr_q <= dump_addr_q + 5'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef DIFFTEST_WB_STATS_EN
  logic [31:0] wb_count_q;
  logic [15:0] drop_count_q;
  logic        drop;

  assign drop = push_req && full;

  // Accepted count wraps; dropped count saturates.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (push) wb_count_q <= wb_count_q + 32'd1;
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign wb_count   = wb_count_q;
  assign drop_count = drop_count_q;
`else
  assign wb_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_difftest_int_wb_sink.sv
// Directed bench for difftest_int_wb_sink: dump beats are scoreboarded by a negedge monitor,
// read-port and status checks are made inline by the stimulus process.
module tb_difftest_int_wb_sink;
  localparam int unsigned CORE = 3;

`ifdef DIFFTEST_WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_pending;
  logic        dump_req;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_busy;
  logic [31:0] wb_count;
  logic [15:0] drop_count;

  difftest_int_wb_sink_if wb ();

  difftest_int_wb_sink #(.CORE_ID(CORE), .DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .wb         (wb),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .wb_count   (wb_count),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] cnt(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  // Monitor: pops an expected beat on every handshake and checks that stalled beats hold.
  bit          stall_q = 1'b0;
  logic [4:0]  stall_addr;
  logic [63:0] stall_data;

  always @(negedge clock) begin
    beat_t e;
    if (stall_q && reset_n) begin
      chk("stall_valid", 64'(dump_valid), 64'd1);
      chk("stall_addr", 64'(dump_addr), 64'(stall_addr));
      chk("stall_data", dump_data, stall_data);
    end
    stall_q    = reset_n && dump_valid && !dump_ready;
    stall_addr = dump_addr;
    stall_data = dump_data;
    if (reset_n && dump_valid && dump_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got addr %0d, expected no beat", dump_addr);
      end else begin
        e = sb.pop_front();
        chk("beat_addr", 64'(dump_addr), 64'(e.addr));
        chk("beat_data", dump_data, e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [63:0] d, input logic [7:0] c, input logic en);
    wb.io_valid   = 1'b1;
    wb.io_address = a;
    wb.io_data    = d;
    wb.io_coreid  = c;
    enable        = en;
  endtask

  task automatic idle_in;
    wb.io_valid = 1'b0;
    enable      = 1'b1;
  endtask

  task automatic wait_dump_done(input string name);
    for (int k = 0; k < 100 && dump_busy; k++) tick;
    chk({name, "_busy_done"}, 64'(dump_busy), 64'd0);
    chk({name, "_beats_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    wb.io_valid = 1'b0; wb.io_address = '0; wb.io_data = '0; wb.io_coreid = '0;
    enable = 1'b1; rd_addr = '0; dump_req = 1'b0; dump_ready = 1'b0;
    tick; tick;

    // Reset state
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_dump_valid", 64'(dump_valid), 64'd0);
    chk("rst_dump_addr", 64'(dump_addr), 64'd0);
    chk("rst_dump_busy", 64'(dump_busy), 64'd0);
    chk("rst_io_ready", 64'(wb.io_ready), 64'd1);
    chk("rst_pending", 64'(rd_pending), 64'd0);
    chk("rst_wb_count", 64'(wb_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    reset_n = 1'b1;
    tick;

    // Basic write and read
    rd_addr = 5'd5;
    drive(8'd5, 64'hDEADBEEF_00000001, 8'(CORE), 1'b1);
    tick; idle_in; #1;
    chk("t1_pending", 64'(rd_pending), 64'd1);
    chk("t1_rd_before", rd_data, 64'd0);
    tick;
    chk("t1_rd_data", rd_data, 64'hDEADBEEF_00000001);
    chk("t1_pending_clr", 64'(rd_pending), 64'd0);
    chk("t1_wb_count", 64'(wb_count), cnt(1));

    // Same-register ordering with forwarding
    rd_addr = 5'd3;
    drive(8'd3, 64'hA, 8'(CORE), 1'b1);
    tick;
    drive(8'd3, 64'hB, 8'(CORE), 1'b1);
    tick; idle_in; #1;
    chk("t5_rd_first", rd_data, 64'hA);
    chk("t5_pending", 64'(rd_pending), 64'd1);
    tick;
    chk("t5_rd_second", rd_data, 64'hB);
    chk("t5_pending_clr", 64'(rd_pending), 64'd0);
    chk("t5_wb_count", 64'(wb_count), cnt(3));

    // Filtering: foreign core, addr 0, addr 40, enable low
    rd_addr = 5'd6;
    drive(8'd6, 64'h66, 8'd0, 1'b1);
    tick; #1;
    chk("t2_pending_core", 64'(rd_pending), 64'd0);
    drive(8'd0, 64'h77, 8'(CORE), 1'b1); tick;
    drive(8'd40, 64'h88, 8'(CORE), 1'b1); tick;
    drive(8'd7, 64'h99, 8'(CORE), 1'b0); tick;
    idle_in; tick;
    foreach (rd_addr[i]) begin end
    for (int r = 0; r < 4; r++) begin
      rd_addr = (r == 0) ? 5'd0 : (r == 1) ? 5'd6 : (r == 2) ? 5'd8 : 5'd7;
      tick;
      chk("t2_rd_zero", rd_data, 64'd0);
      chk("t2_pending_zero", 64'(rd_pending), 64'd0);
    end
    chk("t2_wb_count", 64'(wb_count), cnt(3));
    chk("t2_drop_count", 64'(drop_count), 64'd0);

    // Reset mid-dump with three FIFO entries
    dump_ready = 1'b0;
    dump_req = 1'b1; tick; dump_req = 1'b0;
    chk("t6_dump_started", 64'(dump_valid), 64'd1);
    for (int i = 10; i <= 12; i++) begin
      drive(8'(i), 64'(i), 8'(CORE), 1'b1);
      tick;
    end
    idle_in;
    rd_addr = 5'd11; #1;
    chk("t6_pending_pre", 64'(rd_pending), 64'd1);
    reset_n = 1'b0; tick; reset_n = 1'b1;
    chk("t6_dump_valid", 64'(dump_valid), 64'd0);
    chk("t6_dump_busy", 64'(dump_busy), 64'd0);
    chk("t6_dump_addr", 64'(dump_addr), 64'd0);
    chk("t6_io_ready", 64'(wb.io_ready), 64'd1);
    chk("t6_pending", 64'(rd_pending), 64'd0);
    chk("t6_rd_data", rd_data, 64'd0);
    chk("t6_wb_count", 64'(wb_count), 64'd0);
    chk("t6_drop_count", 64'(drop_count), 64'd0);
    dump_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rd_addr = (r == 0) ? 5'd3 : (r == 1) ? 5'd5 : 5'd11;
      tick;
      chk("t6_rd_cleared", rd_data, 64'd0);
      chk("t6_no_beats", 64'(dump_valid), 64'd0);
    end
    dump_ready = 1'b0;

    // Overflow while dump holds the FIFO; snapshot is the all-zero regfile
    for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: 64'd0});
    dump_req = 1'b1; tick; dump_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(8'(i), 64'(i), 8'(CORE), 1'b1);
      #1;
      chk("t3_io_ready", 64'(wb.io_ready), (i <= 4) ? 64'd1 : 64'd0);
      tick;
    end
    idle_in;
    rd_addr = 5'd4; #1;
    chk("t3_pending_in", 64'(rd_pending), 64'd1);
    rd_addr = 5'd5; #1;
    chk("t3_pending_dropped", 64'(rd_pending), 64'd0);
    chk("t3_io_ready_full", 64'(wb.io_ready), 64'd0);
    chk("t3_drop_count", 64'(drop_count), cnt(4));
    chk("t3_wb_count", 64'(wb_count), cnt(4));
    dump_ready = 1'b1;
    wait_dump_done("t3");
    dump_ready = 1'b0;
    repeat (5) tick;
    for (int i = 1; i <= 8; i++) begin
      rd_addr = 5'(i);
      tick;
      chk("t3_reg", rd_data, (i <= 4) ? 64'(i) : 64'd0);
    end
    chk("t3_io_ready_drained", 64'(wb.io_ready), 64'd1);

    // Dump with stalls and an ignored mid-dump request
    for (int i = 1; i <= 31; i++) begin
      drive(8'(i), 64'(i * 17), 8'(CORE), 1'b1);
      tick;
    end
    idle_in; tick; tick;
    for (int i = 0; i < 32; i++) sb.push_back('{addr: 5'(i), data: 64'(i * 17)});
    dump_req = 1'b1; tick; dump_req = 1'b0;
    chk("t4_first_valid", 64'(dump_valid), 64'd1);
    chk("t4_first_addr", 64'(dump_addr), 64'd0);
    for (int k = 0; k < 200 && dump_busy; k++) begin
      dump_ready = (k % 2) == 1;
      dump_req   = (k == 9);
      tick;
    end
    dump_req = 1'b0;
    dump_ready = 1'b0;
    wait_dump_done("t4");
    repeat (3) tick;
    chk("t4_no_restart", 64'(dump_valid), 64'd0);
    rd_addr = 5'd31;
    tick;
    chk("t4_reg31", rd_data, 64'h20F);
    chk("t4_wb_count", 64'(wb_count), cnt(35));
    chk("t4_drop_count", 64'(drop_count), cnt(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/difftest_int_wb_sink.md
# difftest_int_wb_sink

Receiving end of the difftest integer-writeback event stream. Accepts `(valid, address, data, coreid)` writeback events and buffers them in a small FIFO. Drains them into a 32×64 shadow integer register file. Exposes a registered read port and a handshaked full-register dump sequencer, so that simulation-side checkers in RTL can compare architectural state without DPI.

## Interface
Parameters:
- `CORE_ID`, 0: only events whose `io_coreid` equals this value are accepted.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  gates event acceptance.
- `io_valid`  in  1  writeback event present.
- `io_address`  in  8  destination integer register index.
- `io_data`  in  64  written value.
- `io_coreid`  in  8  source core id.
- `io_ready`  out  1  FIFO not full.
- `rd_addr`  in  5  shadow read index.
- `rd_data`  out  64  registered shadow value.
- `rd_pending`  out  1  a FIFO entry targets `rd_addr`; combinational.
- `dump_req`  in  1  start a full dump; pulse or level.
- `dump_valid`  out  1  dump beat present.
- `dump_ready`  in  1  dump beat consumed.
- `dump_addr`  out  5  dump beat register index.
- `dump_data`  out  64  dump beat value.
- `dump_busy`  out  1  dump in progress.
- `wb_count`  out  32  accepted-event counter; see Configuration.
- `drop_count`  out  16  dropped-event counter; see Configuration.

## Operation
- **Offer condition:** an event is *offered* when `enable && io_valid && io_coreid == CORE_ID`. All other cycles are ignored entirely.
- **Discarded offers:** an offered event with `io_address >= 32` or `io_address == 0` is discarded. It is not pushed, not counted as accepted, and not counted as dropped.
- **Push:** an offered, non-discarded event is pushed when `io_ready == 1`. It is dropped when `io_ready == 0`; the producer has no backpressure. `io_ready = !full`, computed before the same-cycle pop. A push into a full FIFO is dropped even if a pop occurs in the same cycle.
- **Drain:** while not dumping and the FIFO is non-empty, pop one entry per cycle and write `regfile[addr[4:0]] <= data`.
- **Ordering:** FIFO order is preserved. Two events to the same register leave the later value.
- **Register 0:** `regfile[0]` is constant 0.
- **Read port:** `rd_data <= regfile[rd_addr]` every cycle, write-first. A drain write to `rd_addr` at the same edge appears in `rd_data`.
- **Pending flag:** `rd_pending` is the OR over valid FIFO entries of `entry.addr == rd_addr`. It is 0 when `rd_addr == 0`.
- **Dump FSM states:** `IDLE`, `DUMP`.
  - `IDLE`: `dump_req` -> `DUMP` with `dump_addr = 0`.
  - `DUMP`: `dump_valid = 1`; `dump_data = regfile[dump_addr]`, combinational.
  - On `dump_valid && dump_ready`: increment `dump_addr`. If the handshake is at `dump_addr == 31`, go to `IDLE` instead.
  - `dump_req` in `DUMP` is ignored.
- **Dump snapshot:** draining is frozen in `DUMP`, giving a consistent snapshot. Pushes continue until the FIFO is full.
- **Reset values** (any cycle, including mid-dump or with FIFO occupied):
  - regfile all 0, FIFO empty, FSM `IDLE`.
  - `rd_data = 0`, `dump_valid = 0`, `dump_addr = 0`, `dump_busy = 0`.
  - `wb_count = 0`, `drop_count = 0`, `io_ready = 1`.
  - A dump in progress is aborted without further beats.

## Timing
- **Event to visible:** event offered at edge N into an empty FIFO -> regfile written at edge N+1 -> `rd_data` shows it after edge N+1, given `rd_addr` is held.
- **`rd_pending`:** high between edges N and N+1.
- **Backlog latency:** with k entries ahead, drain occurs at edge N+1+k, provided no dump is active.
- **Read latency:** 1 cycle, `rd_addr` -> `rd_data`.
- **Dump duration:** minimum 32 cycles (`dump_ready` held high). The first beat is the cycle after `dump_req` is sampled.
- **Dump beat stability:** `dump_valid` and `dump_addr` are held stable while `dump_ready == 0`.
- **Drain resume:** draining resumes the cycle after the FSM returns to `IDLE`.

## Configuration
- **Macro:** `DIFFTEST_WB_STATS_EN`.
- **Defined:**
  - `wb_count` increments on each push and wraps at 2^32.
  - `drop_count` increments on each dropped event and saturates at 0xFFFF.
- **Undefined:** both outputs are tied to 0 and the counters are not built. Drop behaviour is unchanged.

## Test plan
1. **Basic write and read:** offer addr 5, data 0xDEADBEEF_00000001, coreid = CORE_ID at edge 0; `rd_addr = 5` -> `rd_pending = 1` in cycle 0, `rd_data = 0xDEADBEEF_00000001` after edge 1; `wb_count = 1`.
2. **Filtering:** offers with coreid ≠ CORE_ID, addr 0, addr 40, or `enable = 0` -> regfile unchanged, `rd_data(0) = 0`, counters unchanged.
3. **Overflow:** 8 back-to-back offers (addr 1..8, data = addr) with a dump active, DEPTH = 4 -> first 4 accepted, `io_ready = 0` after the 4th; `drop_count = 4`; after the dump, regs 1..4 = 1..4 and regs 5..8 = 0.
4. **Dump with stalls:** preload reg i = i×0x11 for i = 1..31; `dump_req`; `dump_ready` low every other cycle -> 32 beats, addr 0..31, data 0, 0x11, …, 0x20F. Values hold during stalls, `dump_busy` falls after beat 31, and a `dump_req` mid-dump is ignored.
5. **Same-register ordering plus forwarding:** two back-to-back offers to reg 3 (0xA, then 0xB) -> `rd_data(3)` = 0xA after edge 1, 0xB after edge 2; `rd_pending(3)` drops after edge 2.
6. **Reset mid-operation:** `reset_n = 0` for 1 cycle during a dump with 3 FIFO entries -> next cycle `dump_valid = 0`, `io_ready = 1`, all reads 0, `rd_pending = 0`, counters 0.
